// File: rtl/loac_pkg.sv
// Shared constants and types for the switch reader and its event buffer.
package loac_pkg;

  localparam int unsigned NBITS_TOP           = 8;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam int unsigned FIFO_DEPTH_DEF      = 4;

  typedef logic [NBITS_TOP-1:0] swi_t;
  // Wide enough for the largest legal debounce length (15).
  typedef logic [3:0]           dbc_cnt_t;

endpackage

// File: rtl/swi_reader_evt_fifo.sv
// Event buffer: circular FIFO with valid/ready output, registered head and sticky overflow.
module evt_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             ready_i,
  output logic             overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   occ_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  ptr_t             wr_q, rd_q, rd_next;
  occ_t             count_q, count_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ovf_q, ovf_d;
  logic             pop, full, wr_en;

  always_comb begin
    pop     = (count_q != '0) && ready_i;
    full    = (count_q == occ_t'(DEPTH));
    wr_en   = push_i && (!full || pop);
    rd_next = rd_q + ptr_t'(1);
    count_d = count_q + occ_t'(wr_en) - occ_t'(pop);
    ovf_d   = ovf_q | (push_i && full && !pop);
    // The head register mirrors mem_q[rd_q]; refill it from the next entry,
    // or from the incoming event when the FIFO would otherwise go empty.
    data_d  = data_q;
    if (pop) begin
      if (count_q > occ_t'(1)) data_d = mem_q[rd_next];
      else if (wr_en)          data_d = push_data_i;
    end else if ((count_q == '0) && wr_en) begin
      data_d = push_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (wr_en) wr_q <= wr_q + ptr_t'(1);
      if (pop)   rd_q <= rd_next;
      count_q <= count_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_q] <= push_data_i;
  end

  assign valid_o    = (count_q != '0);
  assign data_o     = data_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/swi_reader.sv
// Switch reader: synchronize, debounce per bit, detect stable edges, buffer change events.
module swi_reader
  import loac_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned FIFO_DEPTH      = FIFO_DEPTH_DEF
) (
  input  logic clk_2,
  input  logic reset,
  input  swi_t SWI,
  output swi_t swi_stable,
  output swi_t swi_rise,
  output swi_t swi_fall,
  output logic evt_valid,
  output swi_t evt_data,
  input  logic evt_ready,
  output logic evt_overflow
);

  localparam dbc_cnt_t CNT_LAST = dbc_cnt_t'(DEBOUNCE_CYCLES - 1);

  swi_t     sync1_q, sync2_q, stable_q, stable_d, rise_q, fall_q;
  dbc_cnt_t cnt_q [NBITS_TOP];
  dbc_cnt_t cnt_d [NBITS_TOP];
  logic     push;

  always_comb begin
    stable_d = stable_q;
    for (int unsigned i = 0; i < NBITS_TOP; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) stable_d[i] = sync2_q[i];
        else                      cnt_d[i]    = cnt_q[i] + dbc_cnt_t'(1);
      end
    end
    push = |(stable_d ^ stable_q);
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      cnt_q    <= '{default: '0};
    end else begin
      sync1_q  <= SWI;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      rise_q   <= stable_d & ~stable_q;
      fall_q   <= ~stable_d & stable_q;
      cnt_q    <= cnt_d;
    end
  end

  evt_fifo #(
    .WIDTH (NBITS_TOP),
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .clk_i       (clk_2),
    .rst_i       (reset),
    .push_i      (push),
    .push_data_i (stable_d),
    .valid_o     (evt_valid),
    .data_o      (evt_data),
    .ready_i     (evt_ready),
    .overflow_o  (evt_overflow)
  );

  assign swi_stable = stable_q;
  assign swi_rise   = rise_q;
  assign swi_fall   = fall_q;

endmodule

// File: tb/tb_swi_reader.sv
// Directed self-checking bench for swi_reader.
module tb_swi_reader;

  logic       clk_2;
  logic       reset;
  logic [7:0] SWI;
  logic [7:0] swi_stable, swi_rise, swi_fall, evt_data;
  logic       evt_valid, evt_ready, evt_overflow;

  int checks = 0;
  int errors = 0;

  swi_reader dut (
    .clk_2        (clk_2),
    .reset        (reset),
    .SWI          (SWI),
    .swi_stable   (swi_stable),
    .swi_rise     (swi_rise),
    .swi_fall     (swi_fall),
    .evt_valid    (evt_valid),
    .evt_data     (evt_data),
    .evt_ready    (evt_ready),
    .evt_overflow (evt_overflow)
  );

  initial begin
    clk_2 = 1'b0;
    forever #5 clk_2 = ~clk_2;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; SWI = 8'h00; evt_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; SWI = 8'h00; evt_ready = 1'b0;
    #1;
    checks++; if (swi_stable !== 8'h00) begin errors++; $display("FAIL reset_stable: got %h expected 00", swi_stable); end
    checks++; if (swi_rise !== 8'h00) begin errors++; $display("FAIL reset_rise: got %h expected 00", swi_rise); end
    checks++; if (swi_fall !== 8'h00) begin errors++; $display("FAIL reset_fall: got %h expected 00", swi_fall); end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", evt_valid); end
    checks++; if (evt_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", evt_data); end
    checks++; if (evt_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", evt_overflow); end
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_debounce();
    logic [7:0] exp_s, exp_r;
    SWI = 8'h05;
    for (int c = 1; c <= 10; c++) begin
      tick();
      exp_s = (c >= 6) ? 8'h05 : 8'h00;
      exp_r = (c == 6) ? 8'h05 : 8'h00;
      checks++; if (swi_stable !== exp_s) begin errors++; $display("FAIL deb_stable c%0d: got %h expected %h", c, swi_stable, exp_s); end
      checks++; if (swi_rise !== exp_r) begin errors++; $display("FAIL deb_rise c%0d: got %h expected %h", c, swi_rise, exp_r); end
    end
    checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL deb_valid: got %b expected 1", evt_valid); end
    checks++; if (evt_data !== 8'h05) begin errors++; $display("FAIL deb_data: got %h expected 05", evt_data); end
  endtask

  task automatic test_glitch();
    SWI = 8'h0D;
    tick(); tick(); tick();
    SWI = 8'h05;
    for (int c = 1; c <= 10; c++) begin
      tick();
      checks++; if (swi_stable !== 8'h05) begin errors++; $display("FAIL gl_stable c%0d: got %h expected 05", c, swi_stable); end
      checks++; if (swi_rise !== 8'h00) begin errors++; $display("FAIL gl_rise c%0d: got %h expected 00", c, swi_rise); end
    end
    checks++; if (evt_data !== 8'h05) begin errors++; $display("FAIL gl_data: got %h expected 05", evt_data); end
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL gl_single_evt: valid %b expected 0", evt_valid); end
  endtask

  task automatic test_overflow();
    logic [7:0] vals [5];
    vals = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      SWI = vals[i];
      repeat (8) tick();
    end
    checks++; if (evt_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", evt_overflow); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid%0d: got %b expected 1", i, evt_valid); end
      checks++; if (evt_data !== vals[i]) begin errors++; $display("FAIL ovf_drain%0d: got %h expected %h", i, evt_data, vals[i]); end
      evt_ready = 1'b1;
      tick();
    end
    evt_ready = 1'b0;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: valid %b expected 0", evt_valid); end
    checks++; if (evt_data !== 8'h0F) begin errors++; $display("FAIL ovf_hold: got %h expected 0F", evt_data); end
    checks++; if (evt_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", evt_overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] fill [4];
    logic [7:0] exp  [4];
    fill = '{8'h01, 8'h03, 8'h07, 8'h0F};
    exp  = '{8'h03, 8'h07, 8'h0F, 8'h1F};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      SWI = fill[i];
      repeat (8) tick();
    end
    SWI = 8'h1F;
    repeat (5) tick();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    checks++; if (swi_stable !== 8'h1F) begin errors++; $display("FAIL fpp_stable: got %h expected 1F", swi_stable); end
    checks++; if (evt_overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf: got %b expected 0", evt_overflow); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL fpp_valid%0d: got %b expected 1", i, evt_valid); end
      checks++; if (evt_data !== exp[i]) begin errors++; $display("FAIL fpp_drain%0d: got %h expected %h", i, evt_data, exp[i]); end
      evt_ready = 1'b1;
      tick();
    end
    evt_ready = 1'b0;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL fpp_empty: valid %b expected 0", evt_valid); end
  endtask

  task automatic test_async_reset();
    int rises;
    do_reset();
    SWI = 8'h01; repeat (8) tick();
    SWI = 8'h03; repeat (8) tick();
    checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL ar_pending: valid %b expected 1", evt_valid); end
    SWI = 8'h07;
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b expected 0", evt_valid); end
    checks++; if (swi_stable !== 8'h00) begin errors++; $display("FAIL ar_stable: got %h expected 00", swi_stable); end
    checks++; if (evt_data !== 8'h00) begin errors++; $display("FAIL ar_data: got %h expected 00", evt_data); end
    SWI = 8'h80;
    tick(); tick();
    reset = 1'b0;
    rises = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (swi_rise == 8'h80) rises++;
    end
    checks++; if (rises !== 1) begin errors++; $display("FAIL ar_rise_count: got %0d expected 1", rises); end
    checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL ar_evt_valid: got %b expected 1", evt_valid); end
    checks++; if (evt_data !== 8'h80) begin errors++; $display("FAIL ar_evt_data: got %h expected 80", evt_data); end
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL ar_single_evt: valid %b expected 0", evt_valid); end
  endtask

  task automatic test_fall();
    logic [7:0] exp_f;
    do_reset();
    SWI = 8'hFF; repeat (8) tick();
    checks++; if (swi_stable !== 8'hFF) begin errors++; $display("FAIL fall_pre: got %h expected FF", swi_stable); end
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    SWI = 8'h00;
    for (int c = 1; c <= 8; c++) begin
      tick();
      exp_f = (c == 6) ? 8'hFF : 8'h00;
      checks++; if (swi_fall !== exp_f) begin errors++; $display("FAIL fall_pulse c%0d: got %h expected %h", c, swi_fall, exp_f); end
      checks++; if (swi_rise !== 8'h00) begin errors++; $display("FAIL fall_rise c%0d: got %h expected 00", c, swi_rise); end
    end
    checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL fall_valid: got %b expected 1", evt_valid); end
    checks++; if (evt_data !== 8'h00) begin errors++; $display("FAIL fall_data: got %h expected 00", evt_data); end
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL fall_single_evt: valid %b expected 0", evt_valid); end
  endtask

  initial begin
    reset = 1'b1; SWI = 8'h00; evt_ready = 1'b0;
    #2;
    test_reset();
    test_debounce();
    test_glitch();
    test_overflow();
    test_full_push_pop();
    test_async_reset();
    test_fall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
